memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Parametrised, sequential RAM arbiter and successor to the single-path combinational memory controller. It serves `CPUS` cores, each with one instruction-cache port and one data-cache port, and shares a single RAM port among them. Grants are registered, held until the RAM reports `ACCESS`, and rotated round-robin so no requestor starves. It sits between the per-core caches (cache_control_if side) and the RAM model.

## Interface
Parameters:
- `CPUS`, 2, number of cores; there are `2*CPUS` requestor slots.
- `WORD_W`, 32, width of address and data words.

Slot numbering: slot `2k` is dcache `k` and slot `2k+1` is icache `k`.

Ports (one clock; reset is synchronous and active-low):
- `CLK`  in  1  clock; all state updates on its rising edge.
- `nRST`  in  1  synchronous, active-low reset.
- `iREN`  in  CPUS  icache read request per core.
- `iaddr`  in  CPUS×WORD_W  icache address per core.
- `dREN`  in  CPUS  dcache read request per core.
- `dWEN`  in  CPUS  dcache write request per core.
- `daddr`  in  CPUS×WORD_W  dcache address per core.
- `dstore`  in  CPUS×WORD_W  dcache write data per core.
- `ramload`  in  WORD_W  RAM read data.
- `ramstate`  in  ramstate_t  RAM status: FREE, BUSY, ACCESS or ERROR.
- `iwait`  out  CPUS  icache wait; 1 while stalled.
- `dwait`  out  CPUS  dcache wait.
- `iload`  out  CPUS×WORD_W  icache read data.
- `dload`  out  CPUS×WORD_W  dcache read data.
- `ramaddr`  out  WORD_W  RAM address.
- `ramstore`  out  WORD_W  RAM write data.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `grant_cnt`  out  2·CPUS×32  completed transactions per slot; present only with `MEMARB_PERF_EN`.

## Operation
- Registered state:
  - `state` ∈ {IDLE, SERVE}.
  - `gnt`, the granted slot index.
  - `rr_ptr`, the round-robin start slot.
- A slot is requesting when:
  - dcache slot: `dWEN[k] | dREN[k]`;
  - icache slot: `iREN[k]`.
- IDLE:
  - No RAM enables are driven.
  - If any slot is requesting, `gnt` takes the first requesting slot at or after `rr_ptr`, searching upward and wrapping modulo `2*CPUS`; `state` moves to SERVE.
  - Otherwise `state` stays IDLE.
- SERVE: the RAM port is driven combinationally from the live inputs of slot `gnt`.
  - dcache slot with `dWEN` set: `ramWEN=1`, `ramaddr=daddr`, `ramstore=dstore`. `dWEN` takes precedence when `dWEN` and `dREN` are both high; `ramREN` stays 0.
  - dcache read: `ramREN=1`, `ramaddr=daddr`.
  - icache read: `ramREN=1`, `ramaddr=iaddr`.
- Completion in SERVE with `ramstate==ACCESS`:
  - The granted wait goes to 0 in the same cycle.
  - For a read, the granted load equals `ramload` in that cycle.
  - Next edge: `state←IDLE`, `rr_ptr←(gnt+1) mod 2*CPUS`.
- Abort: if slot `gnt` drops its request in SERVE, `state←IDLE` on the next edge, no acknowledge is given and `rr_ptr` is unchanged.
- `ramstate==ERROR` in SERVE: the wait stays 1 and `state←IDLE`. The slot re-arbitrates normally and `rr_ptr` is unchanged.
- Non-granted slots always see wait=1 and load=0.
- Reset (`nRST=0` at an edge) takes effect at any point, including mid-SERVE, and the in-flight transaction is dropped without acknowledge:
  - `state←IDLE`, `rr_ptr←0`, `gnt←0`;
  - counters ←0.
- Reset values of the outputs, which remain so until the first grant is in SERVE:
  - all `iwait`/`dwait` = 1;
  - all `iload`/`dload` = 0;
  - `ramaddr` = `ramstore` = 0;
  - `ramREN` = `ramWEN` = 0.

## Timing
- Arbitration takes one cycle. A request first seen in IDLE at cycle 0 drives the RAM port at cycle 1.
- With `ramstate==ACCESS` at cycle 1, the acknowledge (wait low) is at cycle 1. The earliest next grant decision is at cycle 2 and its RAM access at cycle 3.
- The wait is low for exactly one cycle per transaction. A requestor holding its request afterwards is treated as a new request.
- RAM-side outputs are combinational from the registered `gnt` and the slot inputs, with no path from other slots.
- Under full contention, each slot is served once in every `2*CPUS` completions.

## Configuration
- `MEMARB_PERF_EN` defined:
  - adds the `grant_cnt` port and `2*CPUS` 32-bit counters;
  - `grant_cnt[gnt]` increments on the edge after each `ACCESS` completion and wraps at 2^32;
  - aborted and ERROR transactions are not counted.
- Undefined: the port and the counters are absent, and the arbitration behaviour is unchanged.

## Test plan
- Reset, then idle: all waits 1, loads 0, `ramREN`=`ramWEN`=0, `ramaddr`=0 for 5 cycles.
- Core0 `iREN` with `iaddr=0x100` and a RAM `ACCESS` two cycles after its enable, with `ramload=0xDEADBEEF` → `ramREN` high from cycle 1; `iwait[0]`=0 and `iload[0]`=0xDEADBEEF only at cycle 3.
- All four slots requesting continuously with ACCESS on every enabled cycle → completion order 0,1,2,3,0; each slot's wait is low once per 8 cycles.
- Core1 `dWEN` and `dREN` both high, `daddr=0x40`, `dstore=0x1234` → `ramWEN`=1, `ramREN`=0, `ramstore`=0x1234.
- `nRST` asserted during SERVE for a dcache write → next cycle no enables, wait stays 1, `rr_ptr`=0, and after release slot 0 wins first.
- `MEMARB_PERF_EN` build: 3 completions on slot 1 and one abort on slot 2 → `grant_cnt` = {0,3,0,0}.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: registered round-robin arbiter sharing one RAM port among
// CPUS cores, each with a dcache slot (2k) and an icache slot (2k+1).
// A grant is held until the RAM answers ACCESS, the requestor drops its
// request, or the RAM reports ERROR.
// Optional feature macro: MEMARB_PERF_EN adds per-slot completion counters
// on the grant_cnt port.
// ramstate encoding: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
module memory_arbiter #(
   parameter int unsigned CPUS   = 2,
   parameter int unsigned WORD_W = 32
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic [CPUS-1:0]        iREN,
   input  logic [CPUS*WORD_W-1:0] iaddr,
   input  logic [CPUS-1:0]        dREN,
   input  logic [CPUS-1:0]        dWEN,
   input  logic [CPUS*WORD_W-1:0] daddr,
   input  logic [CPUS*WORD_W-1:0] dstore,
   input  logic [WORD_W-1:0]      ramload,
   input  logic [1:0]             ramstate,
   output logic [CPUS-1:0]        iwait,
   output logic [CPUS-1:0]        dwait,
   output logic [CPUS*WORD_W-1:0] iload,
   output logic [CPUS*WORD_W-1:0] dload,
   output logic [WORD_W-1:0]      ramaddr,
   output logic [WORD_W-1:0]      ramstore,
   output logic                   ramREN,
   output logic                   ramWEN
`ifdef MEMARB_PERF_EN
   ,
   output logic [2*CPUS*32-1:0]   grant_cnt
`endif
);

   localparam int unsigned NSLOTS = 2 * CPUS;
   localparam int unsigned SLOT_W = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

   localparam logic [1:0] RamAccess = 2'd2;
   localparam logic [1:0] RamError  = 2'd3;

   typedef enum logic [0:0] {StIdle, StServe} state_e;

   state_e            state_q, state_d;
   logic [SLOT_W-1:0] gnt_q, gnt_d;
   logic [SLOT_W-1:0] rr_ptr_q, rr_ptr_d;

   logic [NSLOTS-1:0] req;
   logic [SLOT_W-1:0] pick;
   logic              any_req;

   // Per-slot request vector: even slots are dcache, odd slots icache.
   always_comb begin
      req = '0;
      for (int unsigned k = 0; k < CPUS; k++) begin
         req[2*k]   = dWEN[k] | dREN[k];
         req[2*k+1] = iREN[k];
      end
   end

   // Round-robin search: first requesting slot at or after rr_ptr_q, wrapping.
   always_comb begin
      int unsigned idx;
      pick    = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int unsigned i = 0; i < NSLOTS; i++) begin
         idx = (32'(rr_ptr_q) + i) % NSLOTS;
         if (!any_req && req[SLOT_W'(idx)]) begin
            any_req = 1'b1;
            pick    = SLOT_W'(idx);
         end
      end
   end

   // Next-state logic for the IDLE/SERVE FSM, grant and round-robin pointer.
   always_comb begin
      int unsigned nxt;
      state_d  = state_q;
      gnt_d    = gnt_q;
      rr_ptr_d = rr_ptr_q;
      nxt      = (32'(gnt_q) + 32'd1) % NSLOTS;
      case (state_q)
         StIdle: begin
            if (any_req) begin
               gnt_d   = pick;
               state_d = StServe;
            end
         end
         StServe: begin
            if (!req[gnt_q]) begin
               // Requestor withdrew: abort silently, fairness pointer untouched.
               state_d = StIdle;
            end else if (ramstate == RamAccess) begin
               state_d  = StIdle;
               rr_ptr_d = SLOT_W'(nxt);
            end else if (ramstate == RamError) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q  <= StIdle;
         gnt_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // RAM port and cache responses, driven only from the granted slot's live inputs.
   always_comb begin
      iwait    = '1;
      dwait    = '1;
      iload    = '0;
      dload    = '0;
      ramaddr  = '0;
      ramstore = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      if (state_q == StServe && req[gnt_q]) begin
         for (int unsigned k = 0; k < CPUS; k++) begin
            if (32'(gnt_q) == 2 * k) begin
               // Write wins over read when both are raised.
               if (dWEN[k]) begin
                  ramWEN   = 1'b1;
                  ramaddr  = daddr[k*WORD_W +: WORD_W];
                  ramstore = dstore[k*WORD_W +: WORD_W];
               end else begin
                  ramREN  = 1'b1;
                  ramaddr = daddr[k*WORD_W +: WORD_W];
               end
               if (ramstate == RamAccess) begin
                  dwait[k] = 1'b0;
                  if (!dWEN[k]) begin
                     dload[k*WORD_W +: WORD_W] = ramload;
                  end
               end
            end
            if (32'(gnt_q) == 2 * k + 1) begin
               ramREN  = 1'b1;
               ramaddr = iaddr[k*WORD_W +: WORD_W];
               if (ramstate == RamAccess) begin
                  iwait[k]                  = 1'b0;
                  iload[k*WORD_W +: WORD_W] = ramload;
               end
            end
         end
      end
   end

`ifdef MEMARB_PERF_EN
   logic                   ack_done;
   logic [NSLOTS-1:0][31:0] cnt_q;

   assign ack_done  = (state_q == StServe) && req[gnt_q] && (ramstate == RamAccess);
   assign grant_cnt = cnt_q;

   // Completed-transaction counters; aborts and errors are not counted.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         cnt_q <= '0;
      end else if (ack_done) begin
         cnt_q[gnt_q] <= cnt_q[gnt_q] + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter (CPUS=2, WORD_W=32).
module tb_memory_arbiter;

   localparam int unsigned CPUS = 2;
   localparam int unsigned W    = 32;
   localparam int unsigned NS   = 2 * CPUS;

   localparam logic [1:0] FREE   = 2'd0;
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] ERROR  = 2'd3;

   logic              CLK;
   logic              nRST;
   logic [CPUS-1:0]   iREN, dREN, dWEN, iwait, dwait;
   logic [CPUS*W-1:0] iaddr, daddr, dstore, iload, dload;
   logic [W-1:0]      ramload, ramaddr, ramstore;
   logic [1:0]        ramstate;
   logic              ramREN, ramWEN;
`ifdef MEMARB_PERF_EN
   logic [NS*32-1:0]  grant_cnt;
`endif

   memory_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .ramload  (ramload),
      .ramstate (ramstate),
      .iwait    (iwait),
      .dwait    (dwait),
      .iload    (iload),
      .dload    (dload),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN)
`ifdef MEMARB_PERF_EN
      ,
      .grant_cnt(grant_cnt)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          slot;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] store;
      logic [31:0] load;
      logic        exp_ren;
      logic        exp_wen;
      logic [31:0] exp_addr;
      logic [31:0] exp_store;
      logic [31:0] exp_load;
      logic        chk_load;
   } vec_t;

   vec_t vecs[6];
   vec_t sb[$];
   int   ord_q[$];

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   function automatic logic slot_wait(input int s);
      return (s % 2 == 0) ? dwait[s/2] : iwait[s/2];
   endfunction

   function automatic logic [31:0] slot_load(input int s);
      return (s % 2 == 0) ? dload[(s/2)*W +: W] : iload[(s/2)*W +: W];
   endfunction

   task automatic clear_req();
      iREN = '0;
      dREN = '0;
      dWEN = '0;
   endtask

   task automatic set_req(input int s, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] store);
      if (s % 2 == 0) begin
         dREN[s/2]           = rd;
         dWEN[s/2]           = wr;
         daddr[(s/2)*W +: W]  = addr;
         dstore[(s/2)*W +: W] = store;
      end else begin
         iREN[s/2]          = 1'b1;
         iaddr[(s/2)*W +: W] = addr;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      vec_t e;
      int   nlow;

      vecs[0] = '{1, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF,
                  1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1};
      vecs[1] = '{0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h55,
                  1'b1, 1'b0, 32'h200, 32'h0, 32'h55, 1'b1};
      vecs[2] = '{2, 1'b1, 1'b1, 32'h40, 32'h1234, 32'hFFFF0000,
                  1'b0, 1'b1, 32'h40, 32'h1234, 32'h0, 1'b0};
      vecs[3] = '{3, 1'b1, 1'b0, 32'hABC, 32'h0, 32'h0BADF00D,
                  1'b1, 1'b0, 32'hABC, 32'h0, 32'h0BADF00D, 1'b1};
      vecs[4] = '{2, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFF,
                  1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFF, 1'b1};
      vecs[5] = '{0, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 32'h1,
                  1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0};

      nRST     = 1'b0;
      iREN     = '0;
      dREN     = '0;
      dWEN     = '0;
      iaddr    = '0;
      daddr    = '0;
      dstore   = '0;
      ramload  = '0;
      ramstate = FREE;
      tick();
      tick();
      nRST = 1'b1;

      // Reset then idle for 5 cycles.
      for (int c = 0; c < 5; c++) begin
         tick();
         #1;
         chk32("idle_iwait", 32'(iwait), 32'h3);
         chk32("idle_dwait", 32'(dwait), 32'h3);
         chk32("idle_iload", iload[31:0] | iload[63:32], 32'h0);
         chk32("idle_dload", dload[31:0] | dload[63:32], 32'h0);
         chk1("idle_ren", ramREN, 1'b0);
         chk1("idle_wen", ramWEN, 1'b0);
         chk32("idle_addr", ramaddr, 32'h0);
      end

      // Table-driven single transactions.
      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         clear_req();
         set_req(v.slot, v.rd, v.wr, v.addr, v.store);
         ramstate = FREE;
         ramload  = v.load;
         sb.push_back(v);
         #1;
         chk1($sformatf("v%0d_arb_ren", i), ramREN, 1'b0);
         tick();
         ramstate = BUSY;
         #1;
         chk1($sformatf("v%0d_ren", i), ramREN, v.exp_ren);
         chk1($sformatf("v%0d_wen", i), ramWEN, v.exp_wen);
         chk32($sformatf("v%0d_addr", i), ramaddr, v.exp_addr);
         chk32($sformatf("v%0d_store", i), ramstore, v.exp_store);
         chk1($sformatf("v%0d_busy_wait", i), slot_wait(v.slot), 1'b1);
         ramstate = ACCESS;
         #1;
         e = sb.pop_front();
         chk1($sformatf("v%0d_ack_wait", i), slot_wait(e.slot), 1'b0);
         if (e.chk_load) chk32($sformatf("v%0d_load", i), slot_load(e.slot), e.exp_load);
         for (int s = 0; s < NS; s++) begin
            if (s != e.slot) begin
               chk1($sformatf("v%0d_other_wait%0d", i, s), slot_wait(s), 1'b1);
               chk32($sformatf("v%0d_other_load%0d", i, s), slot_load(s), 32'h0);
            end
         end
         tick();
         clear_req();
         ramstate = FREE;
         #1;
         chk1($sformatf("v%0d_post_wait", i), slot_wait(e.slot), 1'b1);
      end

      // icache read with ACCESS two cycles after the enable.
      clear_req();
      set_req(1, 1'b1, 1'b0, 32'h100, 32'h0);
      ramload  = 32'hDEADBEEF;
      ramstate = FREE;
      #1;
      chk1("lat_c0_ren", ramREN, 1'b0);
      tick();
      ramstate = BUSY;
      #1;
      chk1("lat_c1_ren", ramREN, 1'b1);
      chk1("lat_c1_wait", iwait[0], 1'b1);
      chk32("lat_c1_load", iload[31:0], 32'h0);
      tick();
      #1;
      chk1("lat_c2_wait", iwait[0], 1'b1);
      tick();
      ramstate = ACCESS;
      #1;
      chk1("lat_c3_wait", iwait[0], 1'b0);
      chk32("lat_c3_load", iload[31:0], 32'hDEADBEEF);
      tick();
      clear_req();
      ramstate = FREE;
      #1;
      chk1("lat_c4_wait", iwait[0], 1'b1);
      chk1("lat_c4_ren", ramREN, 1'b0);

      // Full contention from a fresh reset: order 0,1,2,3,0.
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      for (int s = 0; s < NS; s++) set_req(s, 1'b1, 1'b0, 32'h1000 + 32'(s), 32'h0);
      ramstate = ACCESS;
      ramload  = 32'h600D;
      ord_q    = '{0, 1, 2, 3, 0};
      for (int k = 1; k <= 10; k++) begin
         tick();
         #1;
         nlow = 0;
         for (int s = 0; s < NS; s++) begin
            if (slot_wait(s) == 1'b0) begin
               nlow++;
               if (ord_q.size() == 0) begin
                  chk32("rr_extra_ack", 32'(s), 32'hFFFFFFFF);
               end else begin
                  chk32($sformatf("rr_order_k%0d", k), 32'(s), 32'(ord_q.pop_front()));
               end
            end
         end
         chk32($sformatf("rr_acks_k%0d", k), 32'(nlow), (k % 2 == 1) ? 32'd1 : 32'd0);
      end
      chk32("rr_left", 32'(ord_q.size()), 32'd0);
      clear_req();
      ramstate = FREE;
      tick();

      // Reset during a dcache write in SERVE; slot 0 must then win over slot 2.
      set_req(2, 1'b0, 1'b1, 32'h300, 32'h77);
      tick();
      #1;
      chk1("rst_pre_wen", ramWEN, 1'b1);
      chk32("rst_pre_addr", ramaddr, 32'h300);
      nRST     = 1'b0;
      ramstate = BUSY;
      tick();
      #1;
      chk1("rst_wen", ramWEN, 1'b0);
      chk1("rst_ren", ramREN, 1'b0);
      chk1("rst_wait", dwait[1], 1'b1);
      nRST = 1'b1;
      set_req(0, 1'b1, 1'b0, 32'h500, 32'h0);
      tick();
      #1;
      chk1("rst_win_ren", ramREN, 1'b1);
      chk1("rst_win_wen", ramWEN, 1'b0);
      chk32("rst_win_addr", ramaddr, 32'h500);
      clear_req();
      tick();
      #1;
      chk1("abort_ren", ramREN, 1'b0);

      // ERROR keeps the wait high and forces re-arbitration.
      set_req(3, 1'b1, 1'b0, 32'h600, 32'h0);
      tick();
      ramstate = ERROR;
      #1;
      chk1("err_ren", ramREN, 1'b1);
      chk1("err_wait", iwait[1], 1'b1);
      tick();
      ramstate = FREE;
      #1;
      chk1("err_idle_ren", ramREN, 1'b0);
      tick();
      #1;
      chk1("err_retry_ren", ramREN, 1'b1);
      chk32("err_retry_addr", ramaddr, 32'h600);
      ramstate = ACCESS;
      ramload  = 32'h11;
      #1;
      chk1("err_retry_wait", iwait[1], 1'b0);
      chk32("err_retry_load", iload[63:32], 32'h11);
      tick();
      clear_req();
      ramstate = FREE;
      tick();

`ifdef MEMARB_PERF_EN
      // Three completions on slot 1 and one abort on slot 2.
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      for (int n = 0; n < 3; n++) begin
         set_req(1, 1'b1, 1'b0, 32'h10, 32'h0);
         tick();
         ramstate = ACCESS;
         tick();
         clear_req();
         ramstate = FREE;
      end
      set_req(2, 1'b1, 1'b0, 32'h20, 32'h0);
      tick();
      ramstate = BUSY;
      clear_req();
      tick();
      ramstate = FREE;
      tick();
      #1;
      chk32("perf_cnt0", grant_cnt[0*32 +: 32], 32'd0);
      chk32("perf_cnt1", grant_cnt[1*32 +: 32], 32'd3);
      chk32("perf_cnt2", grant_cnt[2*32 +: 32], 32'd0);
      chk32("perf_cnt3", grant_cnt[3*32 +: 32], 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
